// File: rtl/posit_to_float32.sv
// posit_to_float32
//   Three-stage pipelined converter from posit(32,2) to IEEE-754 binary32.
//   Every posit(32,2) magnitude (scale -120..+120) lands on a normal binary32,
//   so there are no overflow or denormal paths.
//
//   Optional build macro: P2F_ROUND_EN
//     defined   : round-to-nearest-even on the 23-bit mantissa
//     undefined : mantissa is truncated (no rounding adder)
//   inexact reports discarded nonzero fraction bits in both builds.
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     input valid, one-cycle qualifier for in_posit
//   in_posit  posit(32,2) operand
//   result    binary32 result (held while done=0)
//   nar       input was NaR (0x80000000)
//   zero      input was 0x00000000
//   inexact   nonzero fraction bits were discarded
//   done      outputs valid; asserted exactly LAT cycles after start
module posit_to_float32 #(
    parameter int NBITS = 32,
    parameter int ES    = 2,
    parameter int LAT   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NBITS-1:0] in_posit,
    output logic [31:0]      result,
    output logic             nar,
    output logic             zero,
    output logic             inexact,
    output logic             done
);

    // Fraction field width below the hidden bit: 31 - 2 (min regime) - ES.
    localparam int FRAC_W = NBITS - 3 - ES;

    if (NBITS != 32 || ES != 2 || LAT != 3) begin : g_unsupported
        $error("posit_to_float32 supports only NBITS=32, ES=2, LAT=3");
    end

    // ---------------- stage 0: input register ----------------
    logic             s0_valid;
    logic [NBITS-1:0] s0_posit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_posit <= '0;
        end else begin
            // An unknown start falls through to the else branch and reads as 0.
            if (start) s0_valid <= 1'b1;
            else       s0_valid <= 1'b0;
            s0_posit <= in_posit;
        end
    end

    // ---------------- stage 0 decode ----------------
    logic              d_sign;
    logic [30:0]       d_mag;
    logic [30:0]       d_run_src;
    logic [5:0]        d_r;
    logic [28:0]       d_body;
    logic [1:0]        d_exp;
    logic [FRAC_W-1:0] d_frac;
    logic [7:0]        d_scale;
    logic              d_zero;
    logic              d_nar;

    assign d_sign    = s0_posit[31];
    assign d_mag     = d_sign ? (~s0_posit[30:0] + 31'd1) : s0_posit[30:0];
    // Regime run of ones becomes a run of zeros, so one leading-zero count serves both.
    assign d_run_src = d_mag[30] ? ~d_mag : d_mag;

    always_comb begin
        logic found;
        found = 1'b0;
        d_r   = 6'd31;
        for (int unsigned i = 0; i < 31; i++) begin
            if (!found && d_run_src[30 - i]) begin
                d_r   = 6'(i);
                found = 1'b1;
            end
        end
    end

    // Bits below the terminating regime bit, left-aligned: mag << (r+1) with the
    // two always-zero low bits dropped. r >= 1 for every encoding.
    assign d_body  = d_mag[28:0] << (d_r - 6'd1);
    assign d_exp   = d_body[28:27];
    assign d_frac  = d_body[26:0];
    // scale = 4k + e; k = r-1 for a ones run, -r for a zeros run (mod-256 two's complement).
    assign d_scale = (d_mag[30] ? {d_r - 6'd1, 2'b00} : (8'd0 - {d_r, 2'b00}))
                     + {6'd0, d_exp};
    assign d_zero  = (s0_posit == 32'h0000_0000);
    assign d_nar   = (s0_posit == 32'h8000_0000);

    // ---------------- stage 1 register ----------------
    logic              s1_valid;
    logic              s1_sign;
    logic [7:0]        s1_scale;
    logic [FRAC_W-1:0] s1_frac;
    logic              s1_zero;
    logic              s1_nar;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_scale <= '0;
            s1_frac  <= '0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
        end else begin
            s1_valid <= s0_valid;
            s1_sign  <= d_sign;
            s1_scale <= d_scale;
            s1_frac  <= d_frac;
            s1_zero  <= d_zero;
            s1_nar   <= d_nar;
        end
    end

    // ---------------- stage 1 rounding ----------------
    logic [22:0] r_mant_t;
    logic        r_guard;
    logic        r_sticky;
    logic [7:0]  r_biased;
    logic [22:0] r_mant;
    logic [7:0]  r_exp;

    assign r_mant_t = s1_frac[26:4];
    assign r_guard  = s1_frac[3];
    assign r_sticky = |s1_frac[2:0];
    assign r_biased = s1_scale + 8'd127;

`ifdef P2F_ROUND_EN
    logic r_inc;
    logic r_carry;

    assign r_inc              = r_guard & (r_sticky | r_mant_t[0]);
    // Mantissa wraps to zero on carry; biased exponent peaks at 248, no overflow.
    assign {r_carry, r_mant}  = {1'b0, r_mant_t} + {23'd0, r_inc};
    assign r_exp              = r_biased + {7'd0, r_carry};
`else
    assign r_mant = r_mant_t;
    assign r_exp  = r_biased;
`endif

    // ---------------- stage 2 register ----------------
    logic        s2_valid;
    logic        s2_sign;
    logic [7:0]  s2_exp;
    logic [22:0] s2_mant;
    logic        s2_inexact;
    logic        s2_zero;
    logic        s2_nar;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_exp     <= '0;
            s2_mant    <= '0;
            s2_inexact <= 1'b0;
            s2_zero    <= 1'b0;
            s2_nar     <= 1'b0;
        end else begin
            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_exp     <= r_exp;
            s2_mant    <= r_mant;
            s2_inexact <= r_guard | r_sticky;
            s2_zero    <= s1_zero;
            s2_nar     <= s1_nar;
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result  <= '0;
            nar     <= 1'b0;
            zero    <= 1'b0;
            inexact <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= s2_valid;
            if (s2_valid) begin
                if (s2_nar) begin
                    result  <= 32'h7FC0_0000;
                    nar     <= 1'b1;
                    zero    <= 1'b0;
                    inexact <= 1'b0;
                end else if (s2_zero) begin
                    result  <= 32'h0000_0000;
                    nar     <= 1'b0;
                    zero    <= 1'b1;
                    inexact <= 1'b0;
                end else begin
                    result  <= {s2_sign, s2_exp, s2_mant};
                    nar     <= 1'b0;
                    zero    <= 1'b0;
                    inexact <= s2_inexact;
                end
            end
        end
    end

endmodule

// File: doc/posit_to_float32.md
Name: posit_to_float32

Overview:
- Pipelined converter from posit(32,2) to IEEE-754 binary32.
- It is the decode direction of the posit arithmetic path: posit results leaving the add/mul units are turned back into float32 for host-side consumption and checking.
- Uses the same start/done pulse protocol as the posit arithmetic units, with fixed latency.
- Every posit(32,2) magnitude (scale −120..+120) maps to a normal binary32, so there are no overflow or denormal paths.

Parameters:
- NBITS, 32, posit width; only 32 is supported.
- ES, 2, posit exponent field width; only 2 is supported.
- LAT, 3, pipeline depth in cycles. Fixed; it exists for documentation and for bench alignment only.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  input valid; a one-cycle qualifier for in_posit.
- in_posit  in  32  posit(32,2) operand.
- result  out  32  binary32 result.
- nar  out  1  input was NaR (0x80000000).
- zero  out  1  input was 0x00000000.
- inexact  out  1  nonzero fraction bits were discarded.
- done  out  1  result/nar/zero/inexact are valid this cycle.

Behaviour:
- Reset: synchronous on rising clk while rst_n=0.
  - All stage valid bits cleared; result=0, nar=0, zero=0, inexact=0, done=0.
  - Reset mid-flight discards all in-flight operands; no done pulses for them.
- Throughput and latency:
  - One operand accepted per cycle; start may be high on consecutive cycles.
  - done asserts exactly 3 cycles after the start edge it belongs to. Order is preserved.
  - No backpressure.
- Stage 0 (input register, then decode):
  - Capture in_posit and start. An X on start is treated as 0.
  - sign = bit31. If sign=1, mag = two's complement of bits[30:0].
  - Regime: run length r of identical bits starting at mag[30], found with a leading-one/zero count.
    - k = r−1 if the run bits are 1; k = −r if they are 0.
  - Exponent e: the 2 bits after the terminating regime bit. Missing bits read as 0.
  - Fraction: the remaining bits, left-aligned into 27 bits with a hidden 1.
  - scale = 4k + e, signed 8-bit, range −120..+120.
- Stage 1 (register, then round to 23 bits):
  - guard = fraction bit 3; sticky = OR of fraction bits [2:0].
  - RNE: increment when guard & (sticky | mantissa lsb).
  - Carry out of the mantissa increments the biased exponent and clears the mantissa. Max biased exponent is 248, so no overflow is possible.
  - inexact = guard | sticky.
- Stage 2 (register, then output):
  - Normal case: result = {sign, scale+127 (8b), mantissa23}.
  - Zero input: result = 0x00000000, zero=1, inexact=0.
  - NaR input: result = 0x7FC00000, nar=1, inexact=0.
  - Outputs are registered and hold their last value when done=0.

Optional Feature:
- Macro: P2F_ROUND_EN.
- Defined: RNE rounding as described in Stage 1.
- Undefined: the mantissa is truncated (no increment, no exponent carry) and the rounding adder is not synthesised. inexact is still reported as guard | sticky.
- Latency is 3 cycles in both builds.

Test Plan:
- rst_n=0 for 2 cycles, start=1 held during reset -> done=0, result=0 throughout reset. 1.0, −1.0 and 2.0 use the same streaming as the next scenario; maxpos and minpos as in the scenario after it.
- Streaming: start=1 for 3 back-to-back cycles with 0x40000000, 0xC0000000, 0x48000000 -> done high on 3 consecutive cycles starting 3 cycles later; results 0x3F800000, 0xBF800000, 0x40000000.
- Extremes: 0x7FFFFFFF -> 0x7B800000; 0x00000001 -> 0x03800000; both with inexact=0.
- Specials: 0x00000000 -> result 0x00000000, zero=1. 0x80000000 -> result 0x7FC00000, nar=1. nar and zero are never both 1.
- Rounding (P2F_ROUND_EN defined):
  - 0x40000008 -> 0x3F800000, inexact=1 (tie to even).
  - 0x40000018 -> 0x3F800002, inexact=1 (tie rounds up).
  - Without the macro: 0x40000018 -> 0x3F800001.
- Reset mid-operation: start with 0x40000000, then rst_n=0 on the next cycle for 1 cycle -> no done pulse for that operand. A new start 1 cycle after release -> done exactly 3 cycles later.
